// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one combinational 32-bit ALU between NREQ
// requesters. An operation is accepted in IDLE, the ALU is driven from registered operands
// in EXEC, and the captured result is returned to the granted requester in RESP.
// Optional feature: define ALU_ARB_ILLEGAL_OP_EN to flag opcodes outside the legal set
// on resp_err; otherwise resp_err is tied low.
module alu_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  input  logic [NREQ*4-1:0] req_op,
  output logic [NREQ-1:0]   resp_valid,
  input  logic [NREQ-1:0]   resp_ready,
  output logic [31:0]       resp_data,
  output logic              resp_zero,
  output logic              resp_err,
  output logic [31:0]       alu_a,
  output logic [31:0]       alu_b,
  output logic [3:0]        alu_op,
  input  logic [31:0]       alu_out,
  input  logic              alu_zero
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e            state_q;
  logic [IDX_W-1:0]  rr_ptr_q;
  logic [IDX_W-1:0]  grant_q;
  logic [31:0]       a_q;
  logic [31:0]       b_q;
  logic [3:0]        op_q;
  logic [31:0]       data_q;
  logic              zero_q;
  logic [NREQ-1:0]   resp_valid_q;

  logic              sel_found;
  logic [IDX_W-1:0]  sel_idx;
  logic [31:0]       sel_a;
  logic [31:0]       sel_b;
  logic [3:0]        sel_op;

  // Round-robin pick: first valid at or above rr_ptr, then wrap to those below it.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int j = 0; j < int'(NREQ); j++) begin
      if (!sel_found && req_valid[j] && (j >= int'(rr_ptr_q))) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(j);
      end
    end
    for (int j = 0; j < int'(NREQ); j++) begin
      if (!sel_found && req_valid[j] && (j < int'(rr_ptr_q))) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(j);
      end
    end
  end

  // Operand mux for the selected requester.
  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int j = 0; j < int'(NREQ); j++) begin
      if (sel_idx == IDX_W'(j)) begin
        sel_a  = req_a[j*32 +: 32];
        sel_b  = req_b[j*32 +: 32];
        sel_op = req_op[j*4 +: 4];
      end
    end
  end

  // Accept strobe: only in IDLE, and forced low while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (rst_n && (state_q == StIdle) && sel_found) begin
      for (int j = 0; j < int'(NREQ); j++) begin
        req_ready[j] = (sel_idx == IDX_W'(j));
      end
    end
  end

  // Main FSM: latch request, capture ALU result, hold response until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      data_q       <= '0;
      zero_q       <= 1'b0;
      resp_valid_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (sel_found) begin
            a_q     <= sel_a;
            b_q     <= sel_b;
            op_q    <= sel_op;
            grant_q <= sel_idx;
            state_q <= StExec;
          end
        end
        StExec: begin
          data_q       <= alu_out;
          zero_q       <= alu_zero;
          resp_valid_q <= NREQ'(1) << grant_q;
          state_q      <= StResp;
        end
        StResp: begin
          // Only the granted requester's resp_ready matters.
          if (resp_ready[grant_q]) begin
            resp_valid_q <= '0;
            rr_ptr_q     <= (int'(grant_q) == int'(NREQ) - 1) ? '0 : grant_q + IDX_W'(1);
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef ALU_ARB_ILLEGAL_OP_EN
  logic op_legal;
  logic err_q;

  // Legal opcode decode on the latched op.
  always_comb begin
    op_legal = op_q inside {4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111, 4'b1100};
  end

  // Error flag captured alongside the result and held through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (state_q == StExec) begin
      err_q <= !op_legal;
    end
  end

  assign resp_err = err_q;
`else
  assign resp_err = 1'b0;
`endif

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_op     = op_q;
  assign resp_data  = data_q;
  assign resp_zero  = zero_q;
  assign resp_valid = resp_valid_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: constant vector table, rotation, backpressure and reset
// sequences, plus randomized traffic against a scan-from-pointer arbitration model.
module tb_alu_arbiter;

  localparam int NREQ = 4;

`ifdef ALU_ARB_ILLEGAL_OP_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid, req_ready, resp_valid, resp_ready;
  logic [NREQ*32-1:0] req_a, req_b;
  logic [NREQ*4-1:0] req_op;
  logic [31:0]       resp_data, alu_a, alu_b, alu_out;
  logic              resp_zero, resp_err, alu_zero;
  logic [3:0]        alu_op;

  int checks = 0;
  int errors = 0;

  alu_arbiter #(.NREQ(4), .IDX_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_zero(resp_zero), .resp_err(resp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_zero(alu_zero)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
    case (op)
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0111: return a ^ b;
      4'b1100: return ~(a | b);
      default: return 32'h0;
    endcase
  endfunction

  // Behavioural ALU standing in for the real instance.
  always_comb begin
    alu_out  = ref_alu(alu_a, alu_b, alu_op);
    alu_zero = (alu_out == 32'h0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op);
    req_a[r*32 +: 32] = a;
    req_b[r*32 +: 32] = b;
    req_op[r*4 +: 4]  = op;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    #2 rst_n = 1'b1;
    step();
  endtask

  typedef struct {
    int          r;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] data;
    logic        zero;
    logic        err;
  } vec_t;

  vec_t vecs[9];

  // One isolated transaction: accept, EXEC operands, RESP contents, return to IDLE.
  task automatic run_one(input vec_t v);
    logic [3:0] oh;
    oh = 4'(1) << v.r;
    resp_ready = 4'hF;
    set_req(v.r, v.a, v.b, v.op);
    req_valid = oh;
    #1 check("req_ready", 32'(req_ready), 32'(oh));
    step();
    req_valid = '0;
    check("exec_alu_a", alu_a, v.a);
    check("exec_alu_op", 32'(alu_op), 32'(v.op));
    step();
    check("resp_valid", 32'(resp_valid), 32'(oh));
    check("resp_data", resp_data, v.data);
    check("resp_zero", 32'(resp_zero), 32'(v.zero));
    check("resp_err", 32'(resp_err), 32'(v.err));
    step();
    check("resp_done", 32'(resp_valid), 32'h0);
  endtask

  logic [3:0]  legal_ops[6];
  logic [31:0] ma[NREQ];
  logic [31:0] mb[NREQ];
  logic [3:0]  mop[NREQ];

  task automatic rand_req(input int r);
    ma[r]  = $urandom;
    mb[r]  = ($urandom_range(0, 3) == 0) ? ma[r] : $urandom;
    mop[r] = legal_ops[$urandom_range(0, 5)];
    set_req(r, ma[r], mb[r], mop[r]);
  endtask

  initial begin
    logic [31:0] exp_d;
    logic [31:0] held;
    int          ptr;
    int          g;
    logic [3:0]  pat;
    int          nstall;

    legal_ops = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111, 4'b1100};
    vecs[0] = '{0, 32'd5, 32'd3, 4'b0010, 32'd8, 1'b0, 1'b0};
    vecs[1] = '{1, 32'd7, 32'd7, 4'b0110, 32'd0, 1'b1, 1'b0};
    vecs[2] = '{2, 32'd0, 32'd1, 4'b0110, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[3] = '{3, 32'hFF00_FF00, 32'h0F0F_0F0F, 4'b0000, 32'h0F00_0F00, 1'b0, 1'b0};
    vecs[4] = '{0, 32'hFF00_FF00, 32'h0F0F_0F0F, 4'b0001, 32'hFF0F_FF0F, 1'b0, 1'b0};
    vecs[5] = '{1, 32'hFF00_FF00, 32'h0F0F_0F0F, 4'b0111, 32'hF00F_F00F, 1'b0, 1'b0};
    vecs[6] = '{2, 32'hFF00_FF00, 32'h0F0F_0F0F, 4'b1100, 32'h00F0_00F0, 1'b0, 1'b0};
    vecs[7] = '{3, 32'hFFFF_FFFF, 32'd1, 4'b0010, 32'd0, 1'b1, 1'b0};
    vecs[8] = '{1, 32'h1234_5678, 32'd9, 4'b1111, 32'd0, 1'b1, ErrEn};

    rst_n      = 1'b0;
    req_valid  = 4'hF;
    resp_ready = 4'hF;
    req_a      = '0;
    req_b      = '0;
    req_op     = '0;
    #12;
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_resp_data", resp_data, 32'h0);
    check("rst_resp_zero", 32'(resp_zero), 32'h0);
    check("rst_resp_err", 32'(resp_err), 32'h0);
    check("rst_alu_a", alu_a, 32'h0);
    check("rst_alu_b", alu_b, 32'h0);
    check("rst_alu_op", 32'(alu_op), 32'h0);
    req_valid = '0;
    do_reset();

    // Constant vector table.
    for (int i = 0; i < 9; i++) run_one(vecs[i]);

    // All requesters continuously valid from rr_ptr=0: rotation 0,1,2,3,0,... every 3 cycles.
    do_reset();
    for (int r = 0; r < NREQ; r++) rand_req(r);
    req_valid  = 4'hF;
    resp_ready = 4'hF;
    #1;
    for (int k = 0; k < 9; k++) begin
      g = k % NREQ;
      check("rr_grant", 32'(req_ready), 32'(4'(1) << g));
      step();
      check("rr_exec_ready", 32'(req_ready), 32'h0);
      step();
      exp_d = ref_alu(ma[g], mb[g], mop[g]);
      check("rr_resp_valid", 32'(resp_valid), 32'(4'(1) << g));
      check("rr_resp_data", resp_data, exp_d);
      check("rr_resp_zero", 32'(resp_zero), 32'(exp_d == 0));
      rand_req(g);
      step();
    end
    req_valid = '0;
    step();

    // Backpressure on requester 2 while everyone else is clamouring.
    do_reset();
    set_req(2, 32'd10, 32'd20, 4'b0010);
    req_valid = 4'b0100;
    #1 check("bp_accept", 32'(req_ready), 32'h4);
    step();
    req_valid  = 4'hF;
    resp_ready = 4'b1011;
    #1 check("bp_exec_ready", 32'(req_ready), 32'h0);
    step();
    held = resp_data;
    check("bp_data", resp_data, 32'd30);
    for (int c = 0; c < 5; c++) begin
      check("bp_hold_valid", 32'(resp_valid), 32'h4);
      check("bp_hold_data", resp_data, 32'd30);
      check("bp_hold_ready", 32'(req_ready), 32'h0);
      step();
    end
    resp_ready = 4'hF;
    #1 check("bp_still_valid", 32'(resp_valid), 32'h4);
    step();
    check("bp_done", 32'(resp_valid), 32'h0);
    check("bp_next_grant", 32'(req_ready), 32'h8);
    req_valid = '0;
    step();

    // Reset during EXEC after moving rr_ptr away from 0.
    do_reset();
    run_one('{1, 32'd2, 32'd2, 4'b0010, 32'd4, 1'b0, 1'b0});
    set_req(3, 32'hDEAD_BEEF, 32'd1, 4'b0010);
    req_valid = 4'b1000;
    step();
    check("mid_exec_a", alu_a, 32'hDEAD_BEEF);
    req_valid = 4'hF;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_alu_a", alu_a, 32'h0);
    check("mid_rst_alu_op", 32'(alu_op), 32'h0);
    check("mid_rst_resp_valid", 32'(resp_valid), 32'h0);
    check("mid_rst_resp_data", resp_data, 32'h0);
    check("mid_rst_req_ready", 32'(req_ready), 32'h0);
    req_valid = '0;
    step();
    #2 rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      check("post_rst_no_resp", 32'(resp_valid), 32'h0);
    end
    req_valid = 4'hF;
    #1 check("post_rst_grant0", 32'(req_ready), 32'h1);
    req_valid = '0;
    step();

    // Randomized traffic against a scan-from-pointer model with random response stalls.
    do_reset();
    ptr = 0;
    for (int t = 0; t < 40; t++) begin
      for (int r = 0; r < NREQ; r++) rand_req(r);
      pat = 4'($urandom_range(1, 15));
      req_valid  = pat;
      resp_ready = 4'hF;
      g = -1;
      for (int s = 0; s < NREQ; s++) begin
        if (g < 0 && pat[(ptr + s) % NREQ]) g = (ptr + s) % NREQ;
      end
      #1 check("rnd_grant", 32'(req_ready), 32'(4'(1) << g));
      step();
      req_valid = 4'(~pat) | 4'($urandom_range(0, 15));
      step();
      exp_d = ref_alu(ma[g], mb[g], mop[g]);
      nstall = $urandom_range(0, 2);
      for (int c = 0; c < nstall; c++) begin
        resp_ready = 4'($urandom_range(0, 15)) & ~(4'(1) << g);
        check("rnd_stall_ready", 32'(req_ready), 32'h0);
        step();
      end
      check("rnd_resp_valid", 32'(resp_valid), 32'(4'(1) << g));
      check("rnd_resp_data", resp_data, exp_d);
      check("rnd_resp_zero", 32'(resp_zero), 32'(exp_d == 0));
      resp_ready = 4'hF;
      req_valid  = '0;
      step();
      check("rnd_done", 32'(resp_valid), 32'h0);
      ptr = (g + 1) % NREQ;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single-cycle combinational integer ALU between NREQ independent requesters, e.g. the execute stage, branch-compare unit and address-generation helper.
- Accepts operand/opcode bundles over per-requester valid/ready handshakes and grants round-robin.
- Drives the ALU from registered operands, captures result and zero flag, then returns them on a per-requester response handshake.
- Sits between the requesting units and the ALU instance; the ALU itself is unchanged.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDX_W, 2, grant index width; must satisfy 2**IDX_W >= NREQ.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  requester i has an operation pending.
- req_ready  out  NREQ  one-hot; operation of requester i accepted this cycle.
- req_a  in  NREQ*32  operand A, slice i = bits [32i+31:32i].
- req_b  in  NREQ*32  operand B, same slicing.
- req_op  in  NREQ*4  opcode, slice i = bits [4i+3:4i].
- resp_valid  out  NREQ  one-hot; result for requester i available.
- resp_ready  in  NREQ  requester i consumes its result.
- resp_data  out  32  captured ALU result.
- resp_zero  out  1  captured zero flag.
- resp_err  out  1  illegal opcode flag (see Optional Feature; tied 0 when disabled).
- alu_a, alu_b  out  32 each  operands to the ALU.
- alu_op  out  4  opcode to the ALU.
- alu_out  in  32  ALU result (combinational).
- alu_zero  in  1  ALU zero flag.

Behaviour:
- Opcodes: ADD 4'b0010, SUB 4'b0110, AND 4'b0000, OR 4'b0001, XOR 4'b0111, NOR 4'b1100. Any other code is passed through; the ALU returns 0 with zero=1.
- FSM states: IDLE, EXEC, RESP.
- Reset, asynchronous, rst_n low:
  - state=IDLE, rr_ptr=0, grant=0.
  - All operand/op/result registers 0.
  - req_ready=0, resp_valid=0, resp_data=0, resp_zero=0, resp_err=0.
  - alu_a=alu_b=0, alu_op=4'b0000.
- IDLE:
  - If any req_valid, select the first requester with valid set, scanning from rr_ptr upward and wrapping modulo NREQ.
  - In the same cycle, assert req_ready for that requester only (combinational from req_valid and rr_ptr).
  - At the clock edge, latch its a/b/op and grant index; next state is EXEC.
  - If no req_valid, stay in IDLE with req_ready=0.
- EXEC:
  - alu_a/alu_b/alu_op are driven from the latched registers; they are stable for the whole state and hold their value in all other states.
  - At the edge, capture alu_out into resp_data and alu_zero into resp_zero; next state is RESP.
- RESP:
  - resp_valid is one-hot at the grant index.
  - Hold resp_data/resp_zero/resp_err stable until resp_ready[grant]=1 at a clock edge.
  - On that edge: resp_valid drops, rr_ptr = (grant+1) mod NREQ, next state is IDLE.
  - resp_ready bits for non-granted requesters are ignored.
- Latency: accept at cycle 0, resp_valid at cycle 2. Peak throughput is one op per 3 cycles.
- req_ready is never asserted outside IDLE. A requester deasserting req_valid before being granted loses nothing.
- Simultaneous requests: exactly one is granted. rr_ptr advances only on response completion, so a continuously requesting set is served in rotation and no requester starves.
- rr_ptr wraps from NREQ-1 to 0.
- Reset mid-operation (EXEC or RESP) abandons the operation; no response is produced after rst_n rises.
- Arithmetic is 32-bit two's complement, wrap-around, no overflow flag.

Optional Feature:
- Macro: ALU_ARB_ILLEGAL_OP_EN.
- Defined: an opcode outside the six legal codes sets resp_err=1 in RESP. resp_data=0, resp_zero=1 still apply, and the ALU is still driven.
- Not defined: resp_err is constant 0 and no opcode decoding logic exists.

Test Plan:
- Single request: req0 a=5, b=3, op=ADD, resp_ready held 1 -> req_ready[0] in cycle 0; resp_valid=4'b0001 with resp_data=8, resp_zero=0 in cycle 2; back to IDLE in cycle 3.
- SUB to zero: a=7, b=7, op=SUB -> resp_data=0, resp_zero=1. Also a=0, b=1, op=SUB -> resp_data=32'hFFFFFFFF.
- All four requesters valid continuously, rr_ptr=0 -> grants in order 0,1,2,3,0, one grant per 3 cycles. Each resp_valid bit matches its own operands (AND/OR/XOR/NOR checked against a reference model).
- Backpressure: resp_ready[2]=0 for 5 cycles during requester 2's response -> resp_valid and resp_data stable, req_ready stays 0 for all requesters. Completion occurs on the first cycle resp_ready[2]=1.
- Reset mid-op: rst_n pulled low during EXEC -> all outputs 0 immediately (asynchronously), no resp_valid after release, next grant starts from requester 0.
- With ALU_ARB_ILLEGAL_OP_EN: op=4'b1111 -> resp_err=1, resp_data=0, resp_zero=1. Without the macro: resp_err=0 for the same op.
